// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline slice.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } wb_state_t;

   localparam logic RESULT_ALU = 1'b0;
   localparam logic RESULT_MEM = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // Count events, stop at all-ones; clear has priority over an increment.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/writeback_cycle.sv
// Write-back stage: result select, write-enable gating, ECC trap and ECC statistics.
module writeback_cycle #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RegWriteW,
   input  logic             ResultSrcW,
   input  logic [4:0]       RD_W,
   input  logic [XLEN-1:0]  PCPlus4W,
   input  logic [XLEN-1:0]  ALU_ResultW,
   input  logic [XLEN-1:0]  ReadDataW,
   input  logic             ResultSrcM,
   input  logic             s_err,
   input  logic             d_err,
   input  logic             trap_ack,
   input  logic             cnt_clr,
   output logic [XLEN-1:0]  ResultW,
   output logic             RegWriteW_q,
   output logic [4:0]       RD_Wq,
   output logic             trap_req,
   output logic [XLEN-1:0]  trap_pc,
   output logic [XLEN-1:0]  trap_addr,
   output logic [CNT_W-1:0] s_err_cnt,
   output logic [CNT_W-1:0] d_err_cnt,
   output logic [1:0]       err_sticky
);

   import riscv_pkg::*;

   wb_state_t state, state_nxt;
   logic      s_err_w, d_err_w;
   logic      run;
   logic      s_evt, d_evt;

   // Align ECC flags with the MEM/WB register; only loads qualify them.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_err_w <= 1'b0;
         d_err_w <= 1'b0;
      end else begin
         s_err_w <= s_err & ResultSrcM;
         d_err_w <= d_err & ResultSrcM;
      end
   end

   assign run = (state == RUN);

   // A double error dominates: a simultaneous single error is not counted.
   assign s_evt = run & s_err_w & ~d_err_w;
   assign d_evt = run & d_err_w;

   // Result select and write-enable gating.
   always_comb begin
      ResultW     = (ResultSrcW == RESULT_MEM) ? ReadDataW : ALU_ResultW;
      RegWriteW_q = RegWriteW & ~d_err_w & run;
      RD_Wq       = RD_W;
   end

   // Trap FSM state register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // Trap FSM next-state: enter on a double error in RUN, leave on acknowledge.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (d_err_w)  state_nxt = TRAP;
         TRAP:    if (trap_ack) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign trap_req = (state == TRAP);

   // Capture the faulting load's PC and address when the trap is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_pc   <= '0;
         trap_addr <= '0;
      end else if (d_evt) begin
         trap_pc   <= PCPlus4W - XLEN'(4);
         trap_addr <= ALU_ResultW;
      end
   end

   // Sticky {d_seen, s_seen}; clear wins over a same-cycle event.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr)
         err_sticky <= '0;
      else
         err_sticky <= err_sticky | {d_evt, s_evt};
   end

   sat_counter #(.CNT_W(CNT_W)) u_s_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (s_evt),
      .cnt (s_err_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (d_evt),
      .cnt (d_err_cnt)
   );

endmodule
